// File: rtl/or4_chk_pkg.sv
// rtl/or4_chk_pkg.sv - shared types and constants for the four-input OR response checker
package or4_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int VEC_W     = 4;
    localparam int NUM_VEC   = 16;
    localparam int ERR_VEC_W = 7;

    // Coverage bit for one input vector {a,b,c,d}
    function automatic logic [NUM_VEC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        logic [NUM_VEC-1:0] m;
        m    = '0;
        m[v] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/or4_ref_model.sv
// rtl/or4_ref_model.sv - combinational reference outputs of the four-input OR gate
module or4_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic exp_e,
    output logic exp_f,
    output logic exp_g
);

    assign exp_e = a | b;
    assign exp_f = c | d;
    assign exp_g = a | b | c | d;

endmodule

// File: rtl/or4_response_checker.sv
// rtl/or4_response_checker.sv - strobed response checker with coverage, error count and first-failure capture
module or4_response_checker
    import or4_chk_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 smp_valid,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    input  logic                 e,
    input  logic                 f,
    input  logic                 g,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [NUM_VEC-1:0]   seen,
    output logic [ERR_VEC_W-1:0] first_err_vec
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t             state;
    state_t             state_nxt;
    logic               exp_e;
    logic               exp_f;
    logic               exp_g;
    logic [VEC_W-1:0]   vec;
    logic               sample_bad;
    logic               check_en;
    logic [NUM_VEC-1:0] seen_nxt;

    or4_ref_model u_ref_model (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .exp_e (exp_e),
        .exp_f (exp_f),
        .exp_g (exp_g)
    );

    assign vec        = {a, b, c, d};
    assign sample_bad = ({e, f, g} != {exp_e, exp_f, exp_g});
    // Samples in IDLE (including the start cycle itself) are never checked
    assign check_en   = smp_valid && !clear && (state != IDLE);
    assign seen_nxt   = seen | (check_en ? vec_onehot(vec) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CHECK;
                CHECK:   if (&seen_nxt) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == CHECK);
        done = (state == DONE);
        pass = (state == DONE) && (err_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen          <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            mismatch      <= 1'b0;
        end else if (clear) begin
            seen          <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            mismatch      <= 1'b0;
        end else begin
            seen     <= seen_nxt;
            mismatch <= check_en && sample_bad;
            if (check_en && sample_bad) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (err_cnt == '0) begin
                    first_err_vec <= {a, b, c, d, e, f, g};
                end
            end
        end
    end

endmodule
